dice_result_decoder: RTL and testbench
======================================

Name: dice_result_decoder

Overview:
- Consumer end of the electronic dice interface: watches the dice's `button` and `throw[2:0]` outputs.
- Detects when a roll has stopped (button released and throw stable) and captures the final face.
- Drives a 7-pip LED face pattern, blinking while rolling.
- Keeps a roll counter, a doubles counter and a sticky illegal-value flag for the board's display/score logic.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles `throw` must hold one value after button release before capture; legal range 1..255.
- BLINK_W, 8: width of the free-running blink counter; its MSB blanks the pips while rolling.
- CNT_W, 8: width of `roll_count` and `double_count`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- button  in  1  same button signal that drives the dice; 1 = rolling
- throw  in  3  dice value; legal 1..6
- result  out  3  last captured legal face
- result_valid  out  1  one-cycle pulse when `result` updates
- pips  out  7  LED face pattern: bit0 C, bit1 TL, bit2 TR, bit3 ML, bit4 MR, bit5 BL, bit6 BR
- rolling  out  1  high in ROLLING and SETTLE
- error  out  1  sticky; set when an illegal value (0 or 7) settles
- roll_count  out  CNT_W  legal rolls captured, saturating
- double_count  out  CNT_W  captures equal to the previous legal capture, saturating

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk, all state on posedge clk.
  - Reset values: state = IDLE; result = 0; result_valid = 0; pips = 0; rolling = 0; error = 0; roll_count = 0; double_count = 0; blink counter = 0; settle counter = 0; have_prev = 0.
  - Reset at any time, including mid-SETTLE, aborts with no capture.
- Blink counter: BLINK_W bits, increments every cycle, wraps; blank = MSB.
- Face decode pat(v):
  - 1 -> 0000001
  - 2 -> 1000010
  - 3 -> 1000011
  - 4 -> 1100110
  - 5 -> 1100111
  - 6 -> 1111110
  - 0, 7 -> 0000000
- FSM (state registered; all outputs registered):
  - IDLE: pips = pat(result); button = 1 -> ROLLING.
  - ROLLING: pips = blank ? 0 : pat(throw); button = 0 -> SETTLE, sample = throw, settle_cnt = 1.
  - SETTLE: pips as ROLLING.
    - button = 1 -> ROLLING; button has priority over capture in the same cycle.
    - else if throw != sample -> sample = throw, settle_cnt = 1.
    - else if settle_cnt == SETTLE_CYCLES -> DONE.
    - else settle_cnt++.
  - DONE, one cycle, acting on sample:
    - If sample is in 1..6:
      - result = sample; result_valid = 1 for exactly this cycle.
      - roll_count++ unless at all-ones.
      - If have_prev and sample == old result, double_count++ unless at all-ones.
      - have_prev = 1.
    - If sample is 0 or 7: error = 1; result, counters and have_prev unchanged; no valid pulse.
    - Next state is IDLE regardless of button; a press in DONE is seen in IDLE next cycle.
- Latency: capture occurs SETTLE_CYCLES cycles after the first SETTLE cycle with a stable value; result_valid rises the cycle after.
- pips in DONE: pat(old result); the new pattern appears in IDLE the cycle after DONE.
- error clears only on rst.
- Counters saturate at 2^CNT_W-1; they never wrap.
- A button glitch shorter than the settle window simply restarts the roll; no partial capture.

Test Plan:
- Reset, then hold button 20 cycles with throw cycling 1..6, release, hold throw = 4 -> result_valid pulses once exactly 4+1 cycles after release; result = 4; pips = 1100110; roll_count = 1; double_count = 0.
- Second roll settling on 4 -> double_count = 1, roll_count = 2; third roll settling on 2 -> double_count stays 1, pips = 1000010.
- After release, throw changes 3 -> 5 at settle cycle 2, then holds 5 -> settle counter restarts; capture of 5 occurs 4 cycles after the change; no capture of 3.
- Re-press button in SETTLE cycle 3 -> state returns to ROLLING, no result_valid, counters unchanged; later release captures normally.
- Settle on throw = 0, then a separate roll settling on 7 -> error = 1 and stays 1; result, roll_count and pips unchanged; no pulse. A following legal 6 -> result = 6, error still 1.
- Assert rst during SETTLE after two legal rolls -> next cycle all outputs zero, state IDLE. With CNT_W = 2, four legal rolls -> roll_count saturates at 3.

Source files
------------

// File: rtl/dice_result_decoder.sv
// Purpose : watch the dice button/throw lines, capture the settled face, drive a 7-pip LED pattern and keep roll/double stats.
// Latency : result/result_valid update SETTLE_CYCLES+1 cycles after the first cycle a stable value is sampled on button release.
// Backpressure: none; result_valid is a one-cycle pulse and the consumer must take it when it appears.
//
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   button        - 1 while the dice is rolling
//   throw         - current dice value, legal 1..6
//   result        - last captured legal face, with a one-cycle result_valid pulse on update
//   pips          - LED pattern (bit0 C, bit1 TL, bit2 TR, bit3 ML, bit4 MR, bit5 BL, bit6 BR), blinks while rolling
//   rolling       - high while rolling or waiting for the value to settle
//   error         - sticky, set when 0 or 7 settles
//   roll_count    - legal captures, saturating
//   double_count  - legal captures equal to the previous legal capture, saturating
module dice_result_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int BLINK_W       = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [2:0]       throw,
    output logic [2:0]       result,
    output logic             result_valid,
    output logic [6:0]       pips,
    output logic             rolling,
    output logic             error,
    output logic [CNT_W-1:0] roll_count,
    output logic [CNT_W-1:0] double_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

    state_t             state, state_d;
    logic [2:0]         sample, sample_d;
    logic [7:0]         settle_cnt, settle_cnt_d;
    logic [BLINK_W-1:0] blink;
    logic               have_prev, have_prev_d;

    logic [2:0]         result_d;
    logic               result_valid_d;
    logic [6:0]         pips_d;
    logic               rolling_d;
    logic               error_d;
    logic [CNT_W-1:0]   roll_count_d;
    logic [CNT_W-1:0]   double_count_d;
    logic               sample_legal;

    function automatic logic [6:0] pat(input logic [2:0] v);
        case (v)
            3'd1:    pat = 7'b0000001;
            3'd2:    pat = 7'b1000010;
            3'd3:    pat = 7'b1000011;
            3'd4:    pat = 7'b1100110;
            3'd5:    pat = 7'b1100111;
            3'd6:    pat = 7'b1111110;
            default: pat = 7'b0000000;
        endcase
    endfunction

    assign sample_legal = (sample != 3'd0) && (sample != 3'd7);

    always_comb begin
        state_d        = state;
        sample_d       = sample;
        settle_cnt_d   = settle_cnt;
        have_prev_d    = have_prev;
        result_d       = result;
        result_valid_d = 1'b0;
        error_d        = error;
        roll_count_d   = roll_count;
        double_count_d = double_count;

        case (state)
            IDLE: begin
                if (button) begin
                    state_d = ROLLING;
                end
            end
            ROLLING: begin
                if (!button) begin
                    state_d      = SETTLE;
                    sample_d     = throw;
                    settle_cnt_d = 8'd1;
                end
            end
            SETTLE: begin
                // A press always wins, even on the cycle the count would complete.
                if (button) begin
                    state_d = ROLLING;
                end else if (throw != sample) begin
                    sample_d     = throw;
                    settle_cnt_d = 8'd1;
                end else if (settle_cnt == SETTLE_N) begin
                    state_d = DONE;
                end else begin
                    settle_cnt_d = settle_cnt + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (sample_legal) begin
                    result_d       = sample;
                    result_valid_d = 1'b1;
                    if (roll_count != '1) begin
                        roll_count_d = roll_count + CNT_W'(1);
                    end
                    // Compare against the face held before this capture.
                    if (have_prev && (sample == result) && (double_count != '1)) begin
                        double_count_d = double_count + CNT_W'(1);
                    end
                    have_prev_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rolling_d = (state_d == ROLLING) || (state_d == SETTLE);

        // Outputs are registered, so they are derived from the state being entered.
        // DONE still shows the old face; the new face appears on entering IDLE.
        case (state_d)
            IDLE:    pips_d = pat(result_d);
            DONE:    pips_d = pat(result);
            default: pips_d = blink[BLINK_W-1] ? 7'b0000000 : pat(throw);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sample       <= 3'd0;
            settle_cnt   <= 8'd0;
            blink        <= '0;
            have_prev    <= 1'b0;
            result       <= 3'd0;
            result_valid <= 1'b0;
            pips         <= 7'b0000000;
            rolling      <= 1'b0;
            error        <= 1'b0;
            roll_count   <= '0;
            double_count <= '0;
        end else begin
            state        <= state_d;
            sample       <= sample_d;
            settle_cnt   <= settle_cnt_d;
            blink        <= blink + BLINK_W'(1);
            have_prev    <= have_prev_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            pips         <= pips_d;
            rolling      <= rolling_d;
            error        <= error_d;
            roll_count   <= roll_count_d;
            double_count <= double_count_d;
        end
    end

endmodule

// File: tb/tb_dice_result_decoder.sv
module tb_dice_result_decoder;

    localparam int N      = 4;
    localparam int BW     = 4;
    localparam int CW     = 3;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          button;
    logic [2:0]    throw;
    logic [2:0]    result;
    logic          result_valid;
    logic [6:0]    pips;
    logic          rolling;
    logic          error;
    logic [CW-1:0] roll_count;
    logic [CW-1:0] double_count;

    dice_result_decoder #(
        .SETTLE_CYCLES(N),
        .BLINK_W      (BW),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button       (button),
        .throw        (throw),
        .result       (result),
        .result_valid (result_valid),
        .pips         (pips),
        .rolling      (rolling),
        .error        (error),
        .roll_count   (roll_count),
        .double_count (double_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int res;
        int pips;
        int rc;
        int dc;
        int err;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: what the board should believe after each roll.
    int  m_last = 0;
    bit  m_have = 0;
    int  m_rc   = 0;
    int  m_dc   = 0;
    int  m_err  = 0;

    function automatic int face(input int v);
        case (v)
            1:       face = 7'b0000001;
            2:       face = 7'b1000010;
            3:       face = 7'b1000011;
            4:       face = 7'b1100110;
            5:       face = 7'b1100111;
            6:       face = 7'b1111110;
            default: face = 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_result", int'(result), e.res);
                chk("pulse_pips", int'(pips), e.pips);
                chk("pulse_roll_count", int'(roll_count), e.rc);
                chk("pulse_double_count", int'(double_count), e.dc);
                chk("pulse_error", int'(error), e.err);
            end
        end
    end

    task automatic apply(input bit b, input int t);
        @(negedge clk);
        button = b;
        throw  = 3'(t);
    endtask

    task automatic press(input int len);
        for (int i = 0; i < len; i++) apply(1'b1, $urandom_range(0, 7));
    endtask

    task automatic seg(input int v, input int len);
        for (int i = 0; i < len; i++) apply(1'b0, v);
    endtask

    // Short (non-capturing) segments, consecutive values distinct; the last one
    // also avoids 'avoid' so it cannot merge into the following final value.
    task automatic short_segs(input int n, input int avoid);
        int prev;
        int v;
        prev = -1;
        for (int i = 0; i < n; i++) begin
            do v = $urandom_range(0, 7);
            while (v == prev || (i == n - 1 && v == avoid));
            seg(v, $urandom_range(1, N));
            prev = v;
        end
    endtask

    // Value held across N+1 sampled edges starting at the release/change edge;
    // capture commits one edge after that, i.e. N+2 edges after the first one.
    task automatic final_seg(input int v);
        @(negedge clk);
        button = 1'b0;
        throw  = 3'(v);
        if (v >= 1 && v <= 6) begin
            exp_t e;
            if (m_rc < CMAX) m_rc++;
            if (m_have && v == m_last && m_dc < CMAX) m_dc++;
            m_last = v;
            m_have = 1'b1;
            e.cyc  = cyc + N + 2;
            e.res  = v;
            e.pips = face(v);
            e.rc   = m_rc;
            e.dc   = m_dc;
            e.err  = m_err;
            q.push_back(e);
        end else begin
            m_err = 1;
        end
        for (int i = 1; i <= N; i++) begin
            @(negedge clk);
            if (i == 1) chk("rolling_in_settle", int'(rolling), 1);
        end
    endtask

    task automatic end_roll();
        repeat ($urandom_range(1, 3)) apply(1'b0, $urandom_range(0, 7));
        repeat (2) @(negedge clk);
        chk("idle_result", int'(result), m_last);
        chk("idle_pips", int'(pips), face(m_last));
        chk("idle_rolling", int'(rolling), 0);
        chk("idle_valid", int'(result_valid), 0);
        chk("idle_error", int'(error), m_err);
        chk("idle_roll_count", int'(roll_count), m_rc);
        chk("idle_double_count", int'(double_count), m_dc);
        chk("idle_pending", q.size(), 0);
    endtask

    task automatic rand_roll();
        int r;
        int fin;
        r = $urandom_range(0, 99);
        if (r < 30 && m_have)  fin = m_last;
        else if (r < 40)       fin = ($urandom_range(0, 1) == 1) ? 7 : 0;
        else                   fin = $urandom_range(1, 6);
        press($urandom_range(1, 25));
        if ($urandom_range(0, 3) == 0) begin
            short_segs($urandom_range(0, 3), -1);
            press($urandom_range(1, 3));
        end
        short_segs($urandom_range(0, 3), fin);
        final_seg(fin);
        end_roll();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_valid"}, int'(result_valid), 0);
        chk({tag, "_pips"}, int'(pips), 0);
        chk({tag, "_rolling"}, int'(rolling), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_roll_count"}, int'(roll_count), 0);
        chk({tag, "_double_count"}, int'(double_count), 0);
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b0;
        throw  = 3'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Long press with the face cycling, settle on 4.
        for (int i = 0; i < 20; i++) apply(1'b1, (i % 6) + 1);
        final_seg(4);
        end_roll();
        // Same face again is a double; then a different face.
        press(5); final_seg(4); end_roll();
        press(5); final_seg(2); end_roll();
        // Face changes partway through settling; only the later face is captured.
        press(5); seg(3, 2); final_seg(5); end_roll();
        // Re-press during settling (also at the last cycle of the window).
        press(6); seg(1, 3); press(2); final_seg(1); end_roll();
        press(6); seg(3, N); press(1); final_seg(3); end_roll();
        // Illegal faces set the sticky flag without touching result or counters.
        press(4); final_seg(0); end_roll();
        press(4); final_seg(7); end_roll();
        press(4); final_seg(6); end_roll();

        // Reset in the middle of settling aborts everything.
        press(4);
        seg(2, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        chk("midreset_pending", q.size(), 0);
        rst    = 1'b0;
        q.delete();
        m_last = 0;
        m_have = 1'b0;
        m_rc   = 0;
        m_dc   = 0;
        m_err  = 0;

        for (int k = 0; k < 40; k++) rand_roll();

        repeat (4) @(negedge clk);
        chk("final_pending", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
